// File: rtl/mem_access_unit.sv
// Load/store front-end for the synchronous data RAM: byte-addressed requests in,
// word-wide RAM accesses out, with lane extraction, extension and read-modify-write.
module mem_access_unit #(
   parameter int unsigned ADDR_BITS      = 16,
   parameter int unsigned WORD_ADDR_BITS = 13,
   parameter int unsigned DATA_BITS      = 64,
   parameter int unsigned MEM_WORDS      = 8064
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [1:0]                req_size,
   input  logic                      req_signed,
   input  logic [ADDR_BITS-1:0]      req_addr,
   input  logic [DATA_BITS-1:0]      req_wdata,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_BITS-1:0]      rsp_rdata,
   output logic                      rsp_error,
   output logic [WORD_ADDR_BITS-1:0] ram_address,
   output logic                      ram_write,
   output logic [DATA_BITS-1:0]      ram_in,
   input  logic [DATA_BITS-1:0]      ram_out
);

   localparam int unsigned OFF_BITS   = ADDR_BITS - WORD_ADDR_BITS;
   localparam int unsigned SHIFT_BITS = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_WR,
      S_RESP
   } state_t;

   state_t                    state;
   logic                      cap_write;
   logic [1:0]                cap_size;
   logic                      cap_signed;
   logic [WORD_ADDR_BITS-1:0] cap_waddr;
   logic [OFF_BITS-1:0]       cap_off;
   logic [DATA_BITS-1:0]      cap_wdata;

   logic [WORD_ADDR_BITS-1:0] req_waddr;
   logic [OFF_BITS-1:0]       req_off;
   logic                      req_misaligned;
   logic                      req_out_of_range;
   logic [SHIFT_BITS-1:0]     lane_shift;
   logic [DATA_BITS-1:0]      size_mask;
   logic [DATA_BITS-1:0]      shifted;
   logic [DATA_BITS-1:0]      load_ext;
   logic [DATA_BITS-1:0]      merged;

   assign req_waddr        = req_addr[ADDR_BITS-1:OFF_BITS];
   assign req_off          = req_addr[OFF_BITS-1:0];
   assign req_out_of_range = 32'(req_waddr) >= MEM_WORDS;
   assign lane_shift       = SHIFT_BITS'({cap_off, 3'b000});

   // Alignment: the offset must be a multiple of the access size.
   always_comb begin
      req_misaligned = 1'b0;
      unique case (req_size)
         2'd1:    req_misaligned = req_off[0];
         2'd2:    req_misaligned = |req_off[1:0];
         2'd3:    req_misaligned = |req_off;
         default: req_misaligned = 1'b0;
      endcase
   end

   // Lane selection and extension for loads, lane replacement for sub-doubleword stores.
   always_comb begin
      size_mask = '1;
      load_ext  = '0;
      shifted   = ram_out >> lane_shift;
      unique case (cap_size)
         2'd0: begin
            size_mask = DATA_BITS'(8'hFF);
            load_ext  = {{(DATA_BITS-8){cap_signed & shifted[7]}}, shifted[7:0]};
         end
         2'd1: begin
            size_mask = DATA_BITS'(16'hFFFF);
            load_ext  = {{(DATA_BITS-16){cap_signed & shifted[15]}}, shifted[15:0]};
         end
         2'd2: begin
            size_mask = DATA_BITS'(32'hFFFF_FFFF);
            load_ext  = {{(DATA_BITS-32){cap_signed & shifted[31]}}, shifted[31:0]};
         end
         default: begin
            size_mask = '1;
            load_ext  = shifted;
         end
      endcase
      merged = (ram_out & ~(size_mask << lane_shift)) | ((cap_wdata & size_mask) << lane_shift);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_error   <= 1'b0;
         ram_address <= '0;
         ram_write   <= 1'b0;
         ram_in      <= '0;
         cap_write   <= 1'b0;
         cap_size    <= '0;
         cap_signed  <= 1'b0;
         cap_waddr   <= '0;
         cap_off     <= '0;
         cap_wdata   <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (req_valid) begin
                  cap_write  <= req_write;
                  cap_size   <= req_size;
                  cap_signed <= req_signed;
                  cap_waddr  <= req_waddr;
                  cap_off    <= req_off;
                  cap_wdata  <= req_wdata;
                  req_ready  <= 1'b0;
                  if (req_misaligned || req_out_of_range) begin
                     state     <= S_RESP;
                     rsp_valid <= 1'b1;
                     rsp_error <= 1'b1;
                     rsp_rdata <= '0;
                  end else if (req_write && req_size == 2'd3) begin
                     state       <= S_WR;
                     ram_address <= req_waddr;
                     ram_write   <= 1'b1;
                     ram_in      <= req_wdata;
                  end else begin
                     state       <= S_RD;
                     ram_address <= req_waddr;
                  end
               end
            end
            S_RD: begin
               state <= S_CAP;
            end
            S_CAP: begin
               if (cap_write) begin
                  state     <= S_WR;
                  ram_write <= 1'b1;
                  ram_in    <= merged;
               end else begin
                  state       <= S_RESP;
                  ram_address <= '0;
                  rsp_valid   <= 1'b1;
                  rsp_error   <= 1'b0;
                  rsp_rdata   <= load_ext;
               end
            end
            S_WR: begin
               state       <= S_RESP;
               ram_address <= '0;
               ram_write   <= 1'b0;
               ram_in      <= '0;
               rsp_valid   <= 1'b1;
               rsp_error   <= 1'b0;
               rsp_rdata   <= '0;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state     <= S_IDLE;
                  req_ready <= 1'b1;
                  rsp_valid <= 1'b0;
                  rsp_error <= 1'b0;
                  rsp_rdata <= '0;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: byte-array reference model, RAM model,
// directed scenarios followed by randomized traffic with random back-pressure.
module tb_mem_access_unit;

   logic        clock;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [15:0] req_addr;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rdata;
   logic        rsp_error;
   logic [12:0] ram_address;
   logic        ram_write;
   logic [63:0] ram_in;
   logic [63:0] ram_out;

   mem_access_unit dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .ram_address(ram_address),
      .ram_write(ram_write), .ram_in(ram_in), .ram_out(ram_out)
   );

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        sbq[$];
   logic [63:0] tb_ram [0:8191];
   logic [7:0]  ref_bytes [0:65535];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   bit          first_seen = 0;
   bit          auto_rdy = 0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   // Synchronous RAM: write on enable, registered read of the addressed word.
   always @(posedge clock) begin
      if (ram_write) tb_ram[ram_address] <= ram_in;
      ram_out <= tb_ram[ram_address];
   end

   initial begin
      forever begin
         @(posedge clock);
         #2;
         if (auto_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference: memory as a byte array, sizes as byte counts.
   task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [15:0] a, input logic [63:0] wd,
                        output logic [63:0] rd, output logic er, output int lat);
      int n = 1 << sz;
      int ai = int'(a);
      rd = '0;
      er = ((ai % n) != 0) || ((ai / 8) >= 8064);
      lat = 1;
      if (er) return;
      if (w) begin
         for (int i = 0; i < n; i++) ref_bytes[ai + i] = wd[8*i +: 8];
         lat = (n == 8) ? 2 : 4;
      end else begin
         for (int i = 0; i < n; i++) rd = rd | (64'(ref_bytes[ai + i]) << (8 * i));
         if (sg && rd[8*n-1]) rd = rd | ({64{1'b1}} << (8 * n));
         lat = 3;
      end
   endtask

   task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [15:0] a, input logic [63:0] wd, input bit expect_rsp);
      int   k = 0;
      exp_t e;
      @(negedge clock);
      while (!req_ready && k < 300) begin
         @(negedge clock);
         k++;
      end
      chk("issue_ready", 64'(req_ready), 64'(1));
      if (!req_ready) return;
      req_write  = w;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      req_valid  = 1'b1;
      if (expect_rsp) begin
         model(w, sz, sg, a, wd, e.rdata, e.err, e.lat);
         e.acc = cyc;
         sbq.push_back(e);
      end
      @(negedge clock);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while ((sbq.size() != 0 || rsp_valid) && k < 400) begin
         @(negedge clock);
         k++;
      end
      chk("drain_empty", 64'(sbq.size()), 64'(0));
   endtask

   // Monitor: compare every presented response against the head of the scoreboard.
   always @(negedge clock) begin
      if (!reset_n) begin
         first_seen = 0;
      end else if (rsp_valid) begin
         if (sbq.size() == 0) begin
            chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
         end else begin
            chk("rsp_rdata", rsp_rdata, sbq[0].rdata);
            chk("rsp_error", 64'(rsp_error), 64'(sbq[0].err));
            chk("req_ready_busy", 64'(req_ready), 64'(0));
            if (!first_seen) chk("latency", 64'(cyc - sbq[0].acc), 64'(sbq[0].lat));
            first_seen = 1;
            if (rsp_ready) begin
               void'(sbq.pop_front());
               first_seen = 0;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rw;
      int          bad;
      int          k;
      logic [15:0] a;
      logic [1:0]  sz;
      for (int i = 0; i < 8192; i++) tb_ram[i] = '0;
      for (int i = 0; i < 65536; i++) ref_bytes[i] = '0;
      ram_out = '0;
      reset_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_signed = 1'b0;
      req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

      repeat (3) @(negedge clock);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_rdata", rsp_rdata, 64'(0));
      chk("rst_rsp_error", 64'(rsp_error), 64'(0));
      chk("rst_ram_write", 64'(ram_write), 64'(0));
      chk("rst_ram_address", 64'(ram_address), 64'(0));
      chk("rst_ram_in", ram_in, 64'(0));
      reset_n = 1'b1;
      @(negedge clock);
      chk("rst_req_ready", 64'(req_ready), 64'(1));
      auto_rdy = 1;

      // Round trip, sub-word merges, extension and error cases around word 8.
      issue(1, 2'd3, 0, 16'h0040, 64'h0123_4567_89AB_CDEF, 1);
      issue(0, 2'd3, 0, 16'h0040, '0, 1);
      issue(1, 2'd0, 0, 16'h0043, 64'h0000_0000_0000_00FF, 1);
      issue(0, 2'd3, 0, 16'h0040, '0, 1);
      issue(1, 2'd1, 0, 16'h0046, 64'h5555_5555_5555_1234, 1);
      issue(0, 2'd3, 0, 16'h0040, '0, 1);
      issue(0, 2'd0, 1, 16'h0043, '0, 1);
      issue(0, 2'd0, 0, 16'h0043, '0, 1);
      issue(0, 2'd2, 1, 16'h0044, '0, 1);
      issue(0, 2'd2, 0, 16'h0042, '0, 1);
      issue(0, 2'd3, 0, 16'hFC00, '0, 1);
      issue(1, 2'd3, 0, 16'hFC00, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      drain();

      // Reset while a doubleword store sits in its write cycle.
      issue(1, 2'd3, 0, 16'h0080, 64'hDEAD_BEEF_CAFE_F00D, 0);
      chk("wr_ram_write", 64'(ram_write), 64'(1));
      chk("wr_ram_address", 64'(ram_address), 64'(16));
      #1 reset_n = 1'b0;
      #1;
      chk("async_ram_write", 64'(ram_write), 64'(0));
      chk("async_rsp_valid", 64'(rsp_valid), 64'(0));
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk("post_rst_req_ready", 64'(req_ready), 64'(1));
      issue(0, 2'd3, 0, 16'h0080, '0, 1);
      drain();

      // Back-pressure with a competing request held on the input.
      auto_rdy = 0;
      rsp_ready = 1'b0;
      issue(0, 2'd3, 0, 16'h0040, '0, 1);
      req_write = 1'b1; req_size = 2'd3; req_addr = 16'h0040;
      req_wdata = 64'hBAD0_BAD0_BAD0_BAD0; req_valid = 1'b1;
      k = 0;
      while (!rsp_valid && k < 20) begin
         @(negedge clock);
         k++;
      end
      chk("bp_rsp_seen", 64'(rsp_valid), 64'(1));
      repeat (5) begin
         @(negedge clock);
         chk("bp_req_ready", 64'(req_ready), 64'(0));
         chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
      end
      req_valid = 1'b0;
      @(posedge clock);
      #2;
      rsp_ready = 1'b1;
      auto_rdy = 1;
      drain();

      // Randomized traffic.
      for (int n = 0; n < 250; n++) begin
         sz = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) a = 16'hFC00 + 16'($urandom_range(0, 1023));
         else a = 16'($urandom_range(0, 511));
         if ($urandom_range(0, 3) != 0) a = a & ~((16'd1 << sz) - 16'd1);
         issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
               {$urandom, $urandom}, 1);
      end
      drain();

      bad = 0;
      for (int w = 0; w < 8064; w++) begin
         rw = '0;
         for (int i = 0; i < 8; i++) rw = rw | (64'(ref_bytes[w*8 + i]) << (8 * i));
         if (tb_ram[w] !== rw) bad++;
      end
      chk("mem_final", 64'(bad), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
